// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the five-stage LEGv8 pipeline: EX operand forwarding,
// load-use stall, taken-branch flush, post-reset scrub. Define HAZARD_PERF_CNT_EN for perf counters.
module hazard_ctrl #(
   parameter int INIT_CYCLES = 4
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic [4:0]  id_rn,
   input  logic [4:0]  id_rm,
   input  logic        id_rn_used,
   input  logic        id_rm_used,
   input  logic [4:0]  ex_rn,
   input  logic [4:0]  ex_rm,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic [4:0]  mem_rd,
   input  logic        mem_reg_write,
   input  logic [4:0]  wb_rd,
   input  logic        wb_reg_write,
   input  logic        br_taken,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        idex_bubble,
   output logic        flush,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   typedef enum logic [1:0] {INIT, RUN, STALL, FLUSH} state_t;

   localparam logic [3:0] INIT_RELOAD = 4'(INIT_CYCLES - 1);
   localparam logic [4:0] XZR         = 5'd31;

   state_t     state, state_nxt;
   logic [3:0] init_cnt;
   logic       lu;
   logic       stall_now;

   // EX/MEM beats MEM/WB; XZR is never a forwarding source.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src);
      if (mem_reg_write && mem_rd != XZR && mem_rd == src)
         return 2'b10;
      else if (wb_reg_write && wb_rd != XZR && wb_rd == src)
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign lu = ex_mem_read && ex_rd != XZR &&
               ((id_rn_used && id_rn == ex_rd) || (id_rm_used && id_rm == ex_rd));

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state    <= INIT;
         init_cnt <= INIT_RELOAD;
      end else begin
         state <= state_nxt;
         if (state == INIT && init_cnt != 4'd0)
            init_cnt <= init_cnt - 4'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         INIT:        if (init_cnt == 4'd0) state_nxt = RUN;
         RUN:         if (br_taken) state_nxt = FLUSH;
                      else if (lu) state_nxt = STALL;
         STALL,
         FLUSH:       state_nxt = br_taken ? FLUSH : RUN;
         default:     state_nxt = INIT;
      endcase
   end

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      flush       = 1'b0;
      fwd_a       = fwd_sel(ex_rn);
      fwd_b       = fwd_sel(ex_rm);
      stall_now   = 1'b0;
      case (state)
         INIT: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            flush       = 1'b1;
            fwd_a       = 2'b00;
            fwd_b       = 2'b00;
         end
         RUN: begin
            // A taken branch squashes the would-be stalled instruction anyway.
            if (br_taken) begin
               flush = 1'b1;
            end else if (lu) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               stall_now   = 1'b1;
            end
         end
         default: begin
            // STALL/FLUSH ignore lu so each load causes a single bubble.
            if (br_taken) flush = 1'b1;
         end
      endcase
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         stall_cnt <= 16'h0000;
         flush_cnt <= 16'h0000;
      end else begin
         if (stall_now && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
         if (flush && state != INIT && flush_cnt != 16'hFFFF)
            flush_cnt <= flush_cnt + 16'd1;
      end
   end
`else
   assign stall_cnt = 16'h0000;
   assign flush_cnt = 16'h0000;
`endif

endmodule
